first_nios2_system_sysid_checker: RTL and testbench
===================================================

// Module: first_nios2_system_sysid_checker
// PURPOSE
//  Avalon-MM master that sits directly upstream of the system-ID slave. It reads
//  the ID word (address 0) and the build timestamp (address 1), then compares both
//  against build-time expectations. The result is a pass/fail status for
//  boot-sequencing logic and LEDs, so a wrong or stale FPGA image is caught
//  without any CPU code.
// PARAMETERS
//  EXPECTED_ID     32'h0000_0000  value the slave must return at address 0
//  EXPECTED_TS     32'h5C92_F32F  value the slave must return at address 1
//  CHECK_TS        1              1: timestamp mismatch fails the check; 0: TS is read but ignored
//  TIMEOUT_CYCLES  255            max waitrequest-high cycles per read (0 = no timeout); range 0..65535
//  AUTO_START      1              1: one check starts automatically on the first clock after reset release
// PORTS
//  clock            in   1   system clock
//  reset            in   1   asynchronous, active-high reset
//  start            in   1   pulse; request one check (ignored while busy)
//  avm_address      out  1   word address to the sysid slave (0 = ID, 1 = TS)
//  avm_read         out  1   read strobe
//  avm_readdata     in   32  slave read data; valid in the cycle avm_waitrequest = 0
//  avm_waitrequest  in   1   interconnect stall
//  busy             out  1   check in progress
//  done             out  1   one-cycle pulse; results are valid from this cycle on
//  id_value         out  32  captured ID word
//  ts_value         out  32  captured timestamp word
//  id_ok            out  1   id_value == EXPECTED_ID
//  ts_ok            out  1   ts_value == EXPECTED_TS, or forced to 1 when CHECK_TS = 0
//  pass             out  1   id_ok & ts_ok & ~timeout
//  timeout          out  1   a read exceeded TIMEOUT_CYCLES
// BEHAVIOUR
//  - Reset (async): state IDLE. All outputs are 0, including avm_read, avm_address,
//    the value registers and the flags. Reset mid-read drops avm_read in the same
//    instant and discards the transaction.
//  - FSM: IDLE -> RD_ID -> RD_TS -> REPORT -> IDLE.
//  - IDLE:
//    - start = 1 (or the AUTO_START trigger) moves to RD_ID.
//    - The same edge clears id_ok, ts_ok, pass, timeout, id_value and ts_value.
//  - RD_ID: avm_read = 1, avm_address = 0.
//    - avm_read stays asserted and avm_address stays stable while waitrequest = 1.
//    - On the edge with waitrequest = 0: capture readdata into id_value, register
//      id_ok, go to RD_TS.
//  - RD_TS: same handshake at avm_address = 1.
//    - On capture: register ts_value and ts_ok, go to REPORT.
//  - REPORT: avm_read = 0, done = 1 for exactly one cycle, pass valid; next state IDLE.
//  - busy = 1 in RD_ID, RD_TS and REPORT. avm_read is never asserted outside RD_ID/RD_TS.
//  - Latency with zero waitrequest: start sampled at edge N, so RD_ID during cycle N+1,
//    RD_TS during N+2, done high during N+3. Each waitrequest cycle adds one.
//  - Timeout counter, width clog2(TIMEOUT_CYCLES+1):
//    - Cleared on entry to each read state; increments on each waitrequest = 1 cycle.
//    - When it equals TIMEOUT_CYCLES with waitrequest still 1: deassert avm_read,
//      set timeout = 1, go to REPORT.
//    - On that path the un-read value registers stay 0 and their ok flags stay 0.
//    - waitrequest = 0 on the same edge as the limit is reached counts as success.
//  - start while busy (including in REPORT) is ignored; nothing is queued.
//  - start and the AUTO_START trigger in the same cycle produce one check.
//  - Results hold in IDLE until the next accepted start.
// TESTING
//  1 Zero-wait, readdata 0 then 32'h5C92_F32F, start at t0 -> done at t0+3,
//    id_ok = ts_ok = pass = 1, timeout = 0.
//  2 TS returns 32'h5C92_F330 -> ts_ok = 0, pass = 0. Repeat with CHECK_TS = 0 ->
//    ts_ok = 1, pass = 1.
//  3 waitrequest high 3 cycles on each read -> done at t0+9, address and read stable
//    while stalled, pass = 1.
//  4 TIMEOUT_CYCLES = 4, waitrequest stuck high on the ID read -> avm_read drops after
//    4 stall cycles, done pulses, timeout = 1, pass = 0, id_value = 0.
//  5 Reset asserted during RD_TS -> avm_read = 0 and all flags 0 immediately.
//    With AUTO_START = 1 a fresh check runs after release; a start pulse while busy
//    yields a single done.

Source files
------------

// File: rtl/first_nios2_system_sysid_checker.sv
`default_nettype none
// ============================================================================
// Module   : first_nios2_system_sysid_checker
// Purpose  : Avalon-MM master that reads the system-ID slave (address 0 = ID
//            word, address 1 = build timestamp), compares both against
//            build-time expectations and reports a pass/fail status, so a
//            wrong or stale FPGA image is caught without any CPU code.
// Ports    : clock, reset          - system clock, async active-high reset
//            start                 - pulse, request one check (ignored while busy)
//            avm_address/avm_read  - Avalon-MM read request to the sysid slave
//            avm_readdata          - slave data, valid when avm_waitrequest = 0
//            avm_waitrequest       - interconnect stall
//            busy, done            - check in progress / one-cycle completion
//            id_value, ts_value    - captured ID and timestamp words
//            id_ok, ts_ok, pass    - comparison results
//            timeout               - a read stalled for TIMEOUT_CYCLES cycles
// Revision : 1.0 - initial release
// ============================================================================
module first_nios2_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h5C92_F32F,
    parameter bit          CHECK_TS       = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        pass,
    output logic        timeout
);

    // Counter needs at least one bit even when the timeout is disabled.
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_ID  = 2'd1,
        ST_RD_TS  = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_auto_pending;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [31:0]         r_id_value;
    logic [31:0]         r_ts_value;
    logic                r_id_ok;
    logic                r_ts_ok;
    logic                r_timeout;
    logic                w_trigger;
    logic                w_reading;
    logic                w_limit;
    logic [31:0]         w_cnt_ext;

    // The auto-start request is armed by reset and consumed on the first
    // clock afterwards; OR-ing it with start means a coincident start pulse
    // still yields a single check.
    assign w_trigger = start | r_auto_pending;
    assign w_reading = (r_state == ST_RD_ID) || (r_state == ST_RD_TS);
    assign w_cnt_ext = 32'(r_cnt);

    // The limit is reached on the edge where this stall cycle would bring the
    // counter to TIMEOUT_CYCLES; an acknowledge on that edge still wins.
    assign w_limit = (TIMEOUT_CYCLES != 0) && avm_waitrequest &&
                     ((w_cnt_ext + 32'd1) == TIMEOUT_CYCLES);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_trigger) begin
                    w_next_state = ST_RD_ID;
                end
            end
            ST_RD_ID: begin
                if (!avm_waitrequest) begin
                    w_next_state = ST_RD_TS;
                end else if (w_limit) begin
                    w_next_state = ST_REPORT;
                end
            end
            ST_RD_TS: begin
                if (!avm_waitrequest || w_limit) begin
                    w_next_state = ST_REPORT;
                end
            end
            ST_REPORT: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_auto_pending <= AUTO_START;
            r_cnt          <= '0;
            r_id_value     <= '0;
            r_ts_value     <= '0;
            r_id_ok        <= 1'b0;
            r_ts_ok        <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_auto_pending <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        r_cnt      <= '0;
                        r_id_value <= '0;
                        r_ts_value <= '0;
                        r_id_ok    <= 1'b0;
                        r_ts_ok    <= 1'b0;
                        r_timeout  <= 1'b0;
                    end
                end
                ST_RD_ID: begin
                    if (!avm_waitrequest) begin
                        r_id_value <= avm_readdata;
                        r_id_ok    <= (avm_readdata == EXPECTED_ID);
                        r_cnt      <= '0;
                    end else if (w_limit) begin
                        r_timeout  <= 1'b1;
                    end else begin
                        r_cnt      <= r_cnt + c_CNT_ONE;
                    end
                end
                ST_RD_TS: begin
                    if (!avm_waitrequest) begin
                        r_ts_value <= avm_readdata;
                        r_ts_ok    <= CHECK_TS ? (avm_readdata == EXPECTED_TS) : 1'b1;
                        r_cnt      <= '0;
                    end else if (w_limit) begin
                        r_timeout  <= 1'b1;
                    end else begin
                        r_cnt      <= r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // Bus strobes decode straight from the state register so that an
    // asynchronous reset drops the read in the same instant.
    assign avm_read    = w_reading;
    assign avm_address = (r_state == ST_RD_TS);
    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_REPORT);
    assign id_value    = r_id_value;
    assign ts_value    = r_ts_value;
    assign id_ok       = r_id_ok;
    assign ts_ok       = r_ts_ok;
    assign timeout     = r_timeout;
    assign pass        = r_id_ok & r_ts_ok & ~r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_first_nios2_system_sysid_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_first_nios2_system_sysid_checker
// Purpose  : Self-checking bench. Three checker instances share clock/reset:
//            [0] default parameters, [1] CHECK_TS = 0, [2] TIMEOUT_CYCLES = 4,
//            AUTO_START = 0, EXPECTED_ID = DEADBEEF. Each has its own sysid
//            slave model with programmable stall count or stuck waitrequest.
// Revision : 1.0 - initial release
// ============================================================================
module tb_first_nios2_system_sysid_checker;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  start;
    logic [2:0]  addr;
    logic [2:0]  rd;
    logic [2:0]  wt;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [2:0]  id_ok;
    logic [2:0]  ts_ok;
    logic [2:0]  pass;
    logic [2:0]  tmo;
    logic [31:0] rdata   [3];
    logic [31:0] id_val  [3];
    logic [31:0] ts_val  [3];
    logic [31:0] id_w    [3];
    logic [31:0] ts_w    [3];
    int          stall   [3];
    int          scnt    [3];
    logic [2:0]  stuck;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0       = 0;
    int lat      = 0;
    int ndone    = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    first_nios2_system_sysid_checker u_dut_a (
        .clock(clock), .reset(reset), .start(start[0]),
        .avm_address(addr[0]), .avm_read(rd[0]), .avm_readdata(rdata[0]),
        .avm_waitrequest(wt[0]), .busy(busy[0]), .done(done[0]),
        .id_value(id_val[0]), .ts_value(ts_val[0]), .id_ok(id_ok[0]),
        .ts_ok(ts_ok[0]), .pass(pass[0]), .timeout(tmo[0]));

    first_nios2_system_sysid_checker #(.CHECK_TS(1'b0)) u_dut_b (
        .clock(clock), .reset(reset), .start(start[1]),
        .avm_address(addr[1]), .avm_read(rd[1]), .avm_readdata(rdata[1]),
        .avm_waitrequest(wt[1]), .busy(busy[1]), .done(done[1]),
        .id_value(id_val[1]), .ts_value(ts_val[1]), .id_ok(id_ok[1]),
        .ts_ok(ts_ok[1]), .pass(pass[1]), .timeout(tmo[1]));

    first_nios2_system_sysid_checker #(
        .EXPECTED_ID(32'hDEAD_BEEF), .TIMEOUT_CYCLES(4), .AUTO_START(1'b0)
    ) u_dut_c (
        .clock(clock), .reset(reset), .start(start[2]),
        .avm_address(addr[2]), .avm_read(rd[2]), .avm_readdata(rdata[2]),
        .avm_waitrequest(wt[2]), .busy(busy[2]), .done(done[2]),
        .id_value(id_val[2]), .ts_value(ts_val[2]), .id_ok(id_ok[2]),
        .ts_ok(ts_ok[2]), .pass(pass[2]), .timeout(tmo[2]));

    // Slave models: stall the first stall[i] cycles of every read.
    always @(posedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (!rd[i] || !wt[i]) scnt[i] <= 0;
            else                  scnt[i] <= scnt[i] + 1;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            wt[i]    = rd[i] && (stuck[i] || (scnt[i] < stall[i]));
            rdata[i] = addr[i] ? ts_w[i] : id_w[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Returns sampling in the first RD_ID cycle; t0 marks the start edge.
    task automatic pulse_start(input logic [2:0] mask);
        @(negedge clock);
        start = mask;
        @(posedge clock);
        #1;
        t0    = cyc;
        start = 3'b000;
    endtask

    // Latency counts cycles after the start edge (RD_ID is cycle 1).
    task automatic wait_done(input int i, output int l);
        int b = 0;
        while (!done[i] && b < 40) begin
            tick();
            b++;
        end
        if (!done[i]) chk("done_wait_expired", 32'd0, 32'd1);
        l = cyc - t0 + 1;
    endtask

    initial begin
        reset = 1'b1;
        start = 3'b000;
        stuck = 3'b000;
        for (int i = 0; i < 3; i++) begin
            id_w[i]  = 32'h0;
            ts_w[i]  = 32'h5C92_F32F;
            stall[i] = 0;
        end
        id_w[2] = 32'hDEAD_BEEF;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_read", 32'(rd), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_flags", 32'({id_ok, ts_ok, pass, tmo, done}), 32'd0);
        chk("rst_idval", id_val[0], 32'd0);

        // Auto-start on the first clock after release (A and B only)
        @(negedge clock);
        reset = 1'b0;
        tick();
        t0 = cyc;
        chk("auto_busy", 32'(busy), 32'b011);
        chk("auto_rd_addr", 32'({rd[0], addr[0]}), 32'b10);
        wait_done(0, lat);
        chk("auto_lat", lat, 3);
        chk("auto_pass_a", 32'(pass[0]), 32'd1);
        chk("auto_pass_b", 32'(pass[1]), 32'd1);
        chk("auto_tsval", ts_val[0], 32'h5C92_F32F);
        tick();
        chk("hold_done", 32'(done[0]), 32'd0);
        chk("hold_pass", 32'(pass[0]), 32'd1);

        // 1: zero-wait explicit start
        pulse_start(3'b001);
        chk("t1_clear_pass", 32'(pass[0]), 32'd0);
        wait_done(0, lat);
        chk("t1_lat", lat, 3);
        chk("t1_flags", 32'({id_ok[0], ts_ok[0], pass[0], tmo[0]}), 32'b1110);
        tick();

        // 2: timestamp off by one; CHECK_TS=0 instance ignores it
        ts_w[0] = 32'h5C92_F330;
        ts_w[1] = 32'h5C92_F330;
        pulse_start(3'b011);
        wait_done(0, lat);
        chk("t2_a_flags", 32'({id_ok[0], ts_ok[0], pass[0]}), 32'b100);
        chk("t2_b_flags", 32'({done[1], ts_ok[1], pass[1]}), 32'b111);
        chk("t2_b_tsval", ts_val[1], 32'h5C92_F330);
        ts_w[0] = 32'h5C92_F32F;
        ts_w[1] = 32'h5C92_F32F;
        tick();

        // 3: three stall cycles on each read
        stall[0] = 3;
        pulse_start(3'b001);
        chk("t3_stall_c1", 32'({rd[0], addr[0]}), 32'b10);
        repeat (3) tick();
        chk("t3_stall_c4", 32'({rd[0], addr[0]}), 32'b10);
        tick();
        chk("t3_ts_c5", 32'({rd[0], addr[0]}), 32'b11);
        wait_done(0, lat);
        chk("t3_lat", lat, 9);
        chk("t3_pass", 32'({pass[0], tmo[0]}), 32'b10);
        stall[0] = 0;
        tick();

        // 4: stuck waitrequest on the ID read, TIMEOUT_CYCLES = 4
        stuck[2] = 1'b1;
        pulse_start(3'b100);
        repeat (3) tick();
        chk("t4_read_c4", 32'(rd[2]), 32'd1);
        wait_done(2, lat);
        chk("t4_lat", lat, 5);
        chk("t4_read_drop", 32'(rd[2]), 32'd0);
        chk("t4_flags", 32'({tmo[2], pass[2], id_ok[2], ts_ok[2]}), 32'b1000);
        chk("t4_idval", id_val[2], 32'd0);
        stuck[2] = 1'b0;
        tick();

        // 4b: three stalls stay under the limit
        stall[2] = 3;
        pulse_start(3'b100);
        wait_done(2, lat);
        chk("t4b_lat", lat, 9);
        chk("t4b_flags", 32'({tmo[2], pass[2]}), 32'b01);
        chk("t4b_idval", id_val[2], 32'hDEAD_BEEF);
        stall[2] = 0;
        tick();

        // 5: reset during RD_TS, auto restart, starts while busy ignored
        pulse_start(3'b001);
        tick();
        chk("t5_in_ts", 32'({rd[0], addr[0], id_ok[0]}), 32'b111);
        #2 reset = 1'b1;
        #1;
        chk("t5_rst_read", 32'({rd[0], busy[0]}), 32'b00);
        chk("t5_rst_flags", 32'({id_ok[0], ts_ok[0], pass[0], tmo[0]}), 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        tick();
        chk("t5_auto_busy", 32'(busy[0]), 32'd1);
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            start[0] = (k <= 2);
            tick();
            if (done[0]) ndone++;
        end
        start = 3'b000;
        chk("t5_single_done", ndone, 1);
        chk("t5_pass", 32'({busy[0], pass[0]}), 32'b01);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
